// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its buffer.
package instruction_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] WORD_ALIGN_MASK      = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] WORD_BYTES           = 32'd4;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_stage_fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, instr} pairs with synchronous clear.
module fetch_buffer
  import instruction_fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push & ~clear & ~full;
  assign do_pop  = pop & ~clear & ~empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/instruction_fetch_stage.sv
// Front pipeline stage: generates the PC stream, fetches words from the I-cache and
// presents one buffered instruction/PC pair per cycle to decode.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR,
  parameter int unsigned     FIFO_DEPTH      = 2,
  parameter logic [ILEN-1:0] NOP_INSTRUCTION = NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL_FETCH_STAGE,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  output logic            ICACHE_REQ,
  output logic [XLEN-1:0] ICACHE_ADDR,
  input  logic            ICACHE_READY,
  input  logic            ICACHE_VALID,
  input  logic [ILEN-1:0] ICACHE_DATA,
  output logic [ILEN-1:0] INSTRUCTION,
  output logic [XLEN-1:0] PC_OUT,
  output logic            INSTRUCTION_VALID
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic [XLEN-1:0] last_pc_q;

  logic            push_c;
  logic            pop_c;
  logic            room_c;
  logic            req_c;
  logic            accept_c;

  fetch_entry_t    wr_entry;
  fetch_entry_t    head;
  logic [CW-1:0]   buf_count;
  logic            buf_empty;
  logic            buf_full;

  assign push_c = (state_q == S_WAIT) & ICACHE_VALID & ~BRANCH_TAKEN;
  assign pop_c  = ~STALL_FETCH_STAGE & ~buf_empty & ~BRANCH_TAKEN;

  // Occupancy after this cycle's push/pop must leave a slot for a new request's reply.
  always_comb begin
    room_c = 1'b0;
    if (pop_c)       room_c = 1'b1;
    else if (push_c) room_c = (buf_count < CW'(FIFO_DEPTH - 1));
    else             room_c = ~buf_full;
  end

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    if (!RST && !BRANCH_TAKEN && room_c)
      req_c = (state_q == S_RUN) || ((state_q == S_WAIT) && ICACHE_VALID);

    if (BRANCH_TAKEN) begin
      state_d = ((state_q != S_RUN) && !ICACHE_VALID) ? S_DRAIN : S_RUN;
    end else begin
      unique case (state_q)
        S_RUN:   if (req_c && ICACHE_READY) state_d = S_WAIT;
        S_WAIT:  if (ICACHE_VALID) state_d = (req_c && ICACHE_READY) ? S_WAIT : S_RUN;
        S_DRAIN: if (ICACHE_VALID) state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  assign accept_c = req_c & ICACHE_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_RUN;
      fetch_pc_q    <= RESET_VECTOR;
      inflight_pc_q <= '0;
      last_pc_q     <= '0;
    end else begin
      state_q <= state_d;
      if (BRANCH_TAKEN)  fetch_pc_q <= BRANCH_TARGET & WORD_ALIGN_MASK;
      else if (accept_c) fetch_pc_q <= fetch_pc_q + WORD_BYTES;
      if (accept_c)      inflight_pc_q <= fetch_pc_q;
      if (!buf_empty)    last_pc_q <= head.pc;
    end
  end

  assign wr_entry.pc    = inflight_pc_q;
  assign wr_entry.instr = ICACHE_DATA;

  fetch_buffer #(
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_buffer (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (BRANCH_TAKEN),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (buf_count),
    .empty   (buf_empty),
    .full    (buf_full)
  );

  assign ICACHE_REQ        = req_c;
  assign ICACHE_ADDR       = fetch_pc_q;
  assign INSTRUCTION       = buf_empty ? NOP_INSTRUCTION : head.instr;
  assign PC_OUT            = buf_empty ? last_pc_q : head.pc;
  assign INSTRUCTION_VALID = ~buf_empty;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage with a variable-latency I-cache model.
module tb_instruction_fetch_stage;
  import instruction_fetch_stage_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        STALL_FETCH_STAGE;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        ICACHE_REQ;
  logic [31:0] ICACHE_ADDR;
  logic        ICACHE_READY;
  logic        ICACHE_VALID = 1'b0;
  logic [31:0] ICACHE_DATA  = 32'h0;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;
  logic        INSTRUCTION_VALID;

  int          n_vec   = 0;
  int          n_bad   = 0;
  int          seg_cnt = 0;
  int          lat     = 1;
  int          cyc     = 0;
  int          pend_due = 0;
  bit          pend    = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] last_pc   = 32'h0;
  fetch_entry_t exp_q[$];

  instruction_fetch_stage dut (
    .CLK               (CLK),
    .RST               (RST),
    .STALL_FETCH_STAGE (STALL_FETCH_STAGE),
    .BRANCH_TAKEN      (BRANCH_TAKEN),
    .BRANCH_TARGET     (BRANCH_TARGET),
    .ICACHE_REQ        (ICACHE_REQ),
    .ICACHE_ADDR       (ICACHE_ADDR),
    .ICACHE_READY      (ICACHE_READY),
    .ICACHE_VALID      (ICACHE_VALID),
    .ICACHE_DATA       (ICACHE_DATA),
    .INSTRUCTION       (INSTRUCTION),
    .PC_OUT            (PC_OUT),
    .INSTRUCTION_VALID (INSTRUCTION_VALID)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Cache model: accept seen mid-cycle, reply presented 'lat' cycles later.
  always begin
    @(negedge CLK);
    if (RST) pend = 1'b0;
    else if (ICACHE_REQ && ICACHE_READY) begin
      pend      = 1'b1;
      pend_addr = ICACHE_ADDR;
      pend_due  = cyc + lat;
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (pend && cyc == pend_due) begin
      ICACHE_VALID = 1'b1;
      ICACHE_DATA  = mem_word(pend_addr);
      pend         = 1'b0;
    end else begin
      ICACHE_VALID = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      fetch_entry_t e;
      e.pc    = start + 32'(4 * i);
      e.instr = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic restart_sb(input logic [31:0] start, input int n);
    exp_q.delete();
    seg_cnt = 0;
    push_stream(start, n);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #2;
  endtask

  // Monitor: every instruction decode accepts must be the next expected one.
  task automatic monitor_loop();
    fetch_entry_t e;
    forever begin
      @(negedge CLK);
      if (!RST && INSTRUCTION_VALID && !STALL_FETCH_STAGE && !BRANCH_TAKEN) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL sb_unexpected: got pc 0x%08h, expected no instruction", PC_OUT);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", PC_OUT, e.pc);
          check("sb_instr", INSTRUCTION, e.instr);
          last_pc = e.pc;
          seg_cnt++;
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    STALL_FETCH_STAGE = 1'b0;
    BRANCH_TAKEN = 1'b0;
    BRANCH_TARGET = 32'h0;
    ICACHE_READY = 1'b1;
    lat = 1;
    fork
      monitor_loop();
    join_none

    next_cycle();
    next_cycle();
    check("rst_req",   32'(ICACHE_REQ), 32'd0);
    check("rst_valid", 32'(INSTRUCTION_VALID), 32'd0);
    check("rst_instr", INSTRUCTION, 32'h0000_0013);
    check("rst_pc",    PC_OUT, 32'h0);
    check("rst_addr",  ICACHE_ADDR, 32'h0);

    // Back-to-back fetch with a 1-cycle cache
    restart_sb(32'h0, 32);
    RST = 1'b0;
    #2;
    check("t1_addr0", ICACHE_ADDR, 32'h0);
    check("t1_req0",  32'(ICACHE_REQ), 32'd1);
    next_cycle(); #2;
    check("t1_addr1",  ICACHE_ADDR, 32'h4);
    check("t1_valid1", 32'(INSTRUCTION_VALID), 32'd0);
    next_cycle(); #2;
    check("t1_addr2",  ICACHE_ADDR, 32'h8);
    check("t1_valid2", 32'(INSTRUCTION_VALID), 32'd1);
    check("t1_pc2",    PC_OUT, 32'h0);
    check("t1_instr2", INSTRUCTION, 32'h0050_0093);

    // Stall with PC 0x4 at the head: buffer fills, request drops, head frozen
    next_cycle();
    STALL_FETCH_STAGE = 1'b1;
    #2;
    check("t2_pc", PC_OUT, 32'h4);
    check("t2_req", 32'(ICACHE_REQ), 32'd0);
    for (int i = 0; i < 5; i++) begin
      next_cycle(); #2;
      check("t2_hold_pc",    PC_OUT, 32'h4);
      check("t2_hold_instr", INSTRUCTION, 32'h00A0_0113);
      check("t2_hold_req",   32'(ICACHE_REQ), 32'd0);
    end
    next_cycle();
    STALL_FETCH_STAGE = 1'b0;
    #2;
    check("t2_rel_req",  32'(ICACHE_REQ), 32'd1);
    check("t2_rel_addr", ICACHE_ADDR, 32'hC);
    repeat (4) next_cycle();
    check("t2_seg", 32'(seg_cnt >= 5), 32'd1);

    // Idle, then redirect to 0x100 with nothing outstanding
    next_cycle();
    ICACHE_READY = 1'b0;
    repeat (3) next_cycle();
    #2;
    check("t3_empty_valid", 32'(INSTRUCTION_VALID), 32'd0);
    check("t3_empty_instr", INSTRUCTION, 32'h0000_0013);
    check("t3_hold_pc",     PC_OUT, last_pc);
    check("t3_idle_req",    32'(ICACHE_REQ), 32'd1);
    next_cycle();
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h100;
    ICACHE_READY = 1'b1;
    restart_sb(32'h100, 32);
    #2;
    check("t3_br_req", 32'(ICACHE_REQ), 32'd0);
    next_cycle();
    BRANCH_TAKEN = 1'b0;
    #2;
    check("t3_valid", 32'(INSTRUCTION_VALID), 32'd0);
    check("t3_instr", INSTRUCTION, 32'h0000_0013);
    check("t3_addr",  ICACHE_ADDR, 32'h100);
    check("t3_req",   32'(ICACHE_REQ), 32'd1);
    repeat (6) next_cycle();
    check("t3_seg", 32'(seg_cnt >= 3), 32'd1);

    // Redirect to unaligned 0x103 together with a response and a stall
    next_cycle();
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h103;
    STALL_FETCH_STAGE = 1'b1;
    restart_sb(32'h100, 32);
    #2;
    check("t5_br_req", 32'(ICACHE_REQ), 32'd0);
    next_cycle();
    BRANCH_TAKEN = 1'b0;
    STALL_FETCH_STAGE = 1'b0;
    #2;
    check("t5_valid", 32'(INSTRUCTION_VALID), 32'd0);
    check("t5_instr", INSTRUCTION, 32'h0000_0013);
    check("t5_addr",  ICACHE_ADDR, 32'h100);
    check("t5_req",   32'(ICACHE_REQ), 32'd1);
    repeat (6) next_cycle();
    check("t5_seg", 32'(seg_cnt >= 3), 32'd1);

    // Reset pulse between edges while a fetch is in flight
    next_cycle();
    RST = 1'b1;
    ICACHE_READY = 1'b0;
    exp_q.delete();
    seg_cnt = 0;
    #2;
    check("t6_req",   32'(ICACHE_REQ), 32'd0);
    check("t6_valid", 32'(INSTRUCTION_VALID), 32'd0);
    check("t6_instr", INSTRUCTION, 32'h0000_0013);
    check("t6_pc",    PC_OUT, 32'h0);
    #2;
    RST = 1'b0;

    // 3-cycle cache; redirect to 0x200 while the fetch of 0x8 is outstanding
    next_cycle();
    ICACHE_READY = 1'b1;
    lat = 3;
    push_stream(32'h0, 2);
    #2;
    check("t6_first_addr", ICACHE_ADDR, 32'h0);
    check("t6_first_req",  32'(ICACHE_REQ), 32'd1);
    repeat (8) next_cycle();
    check("t4_pre_seg",  32'(seg_cnt), 32'd2);
    check("t4_pre_addr", ICACHE_ADDR, 32'hC);
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'h200;
    restart_sb(32'h200, 16);
    #2;
    check("t4_br_req", 32'(ICACHE_REQ), 32'd0);
    next_cycle();
    BRANCH_TAKEN = 1'b0;
    #2;
    check("t4_drain_req",   32'(ICACHE_REQ), 32'd0);
    check("t4_drain_addr",  ICACHE_ADDR, 32'h200);
    check("t4_drain_valid", 32'(INSTRUCTION_VALID), 32'd0);
    next_cycle(); #2;
    check("t4_run_req",  32'(ICACHE_REQ), 32'd1);
    check("t4_run_addr", ICACHE_ADDR, 32'h200);
    repeat (8) next_cycle();
    check("t4_seg", 32'(seg_cnt >= 2), 32'd1);

    // PC wrap-around from 0xFFFF_FFFC to 0
    next_cycle();
    BRANCH_TAKEN = 1'b1;
    BRANCH_TARGET = 32'hFFFF_FFF8;
    lat = 1;
    restart_sb(32'hFFFF_FFF8, 16);
    #2;
    check("t7_br_req", 32'(ICACHE_REQ), 32'd0);
    next_cycle();
    BRANCH_TAKEN = 1'b0;
    repeat (12) next_cycle();
    check("t7_seg", 32'(seg_cnt >= 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
